clock_monitor: RTL and testbench

//  Receiving end of a divided clock. Takes a slow square wave (e.g. clk_out of a divider) as sig_in.

---
 rtl/clock_monitor.sv | 180 ++++++++++++++++++
 tb/tb_clock_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Measures the half-period of a slow, asynchronous square wave and tracks lock against EXPECT_HALF.
// Optional min/max half-period statistics are enabled with `define CLOCK_MONITOR_MINMAX_EN.
module clock_monitor #(
    parameter int CNT_W       = 32,
    parameter int EXPECT_HALF = 5000,
    parameter int TOL         = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic                             clk,
    input  logic                             reset,
`ifdef CLOCK_MONITOR_MINMAX_EN
    input  logic                             stats_clr,
    output logic [CNT_W-1:0]                 min_half,
    output logic [CNT_W-1:0]                 max_half,
`endif
    input  logic                             sig_in,
    output logic                             edge_rise,
    output logic                             edge_fall,
    output logic [CNT_W-1:0]                 half_period,
    output logic                             period_valid,
    output logic                             locked,
    output logic                             timeout,
    output logic [1:0]                       dbg_state,
    output logic [$clog2(LOCK_COUNT+1)-1:0]  dbg_match_cnt
);

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   LO      = (EXPECT_HALF > TOL) ? (CNT_W+1)'(EXPECT_HALF - TOL) : '0;
    localparam logic [CNT_W:0]   HI      = (CNT_W+1)'(EXPECT_HALF + TOL);
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [MC_W-1:0]  LOCK_N  = MC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_LOCKED  = 2'd2,
        S_LOST    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic             s1_q, s2_q, s3_q;
    logic             s1_d, s2_d, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_period_q, half_period_d;
    logic             period_valid_q, period_valid_d;
    logic             edge_rise_q, edge_rise_d;
    logic             edge_fall_q, edge_fall_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             edge_det, rise_det, meas_evt, to_evt, match;
    logic [CNT_W-1:0] measured;

    always_comb begin
        edge_det = s2_q ^ s3_q;
        rise_det = s2_q & ~s3_q;
        measured = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        match    = ({1'b0, measured} >= LO) && ({1'b0, measured} <= HI);
        meas_evt = edge_det && (state_q != S_IDLE);
        // An edge on the threshold cycle suppresses the timeout.
        to_evt   = !edge_det && (state_q != S_IDLE) && (cnt_q == TO_M1);
    end

    always_comb begin
        s1_d           = sig_in;
        s2_d           = s1_q;
        s3_d           = s2_q;
        edge_rise_d    = rise_det;
        edge_fall_d    = edge_det & ~rise_det;
        cnt_d          = edge_det ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        period_valid_d = meas_evt;
        half_period_d  = meas_evt ? measured : half_period_q;
        timeout_d      = timeout_q;
        if (edge_det) begin
            timeout_d = 1'b0;
        end else if (to_evt) begin
            timeout_d = 1'b1;
        end
        locked_d    = (state_q == S_LOCKED);
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (edge_det) begin
                    state_d     = S_ACQUIRE;
                    match_cnt_d = '0;
                end
            end
            S_ACQUIRE: begin
                if (meas_evt && match) begin
                    match_cnt_d = match_cnt_q + 1'b1;
                    if ((match_cnt_q + 1'b1) == LOCK_N) state_d = S_LOCKED;
                end else if (meas_evt || to_evt) begin
                    match_cnt_d = '0;
                end
            end
            S_LOCKED: begin
                if ((meas_evt && !match) || to_evt) state_d = S_LOST;
            end
            S_LOST: begin
                if (meas_evt && match) begin
                    state_d     = S_ACQUIRE;
                    match_cnt_d = MC_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            cnt_q          <= '0;
            half_period_q  <= '0;
            period_valid_q <= 1'b0;
            edge_rise_q    <= 1'b0;
            edge_fall_q    <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
            state_q        <= S_IDLE;
            match_cnt_q    <= '0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            cnt_q          <= cnt_d;
            half_period_q  <= half_period_d;
            period_valid_q <= period_valid_d;
            edge_rise_q    <= edge_rise_d;
            edge_fall_q    <= edge_fall_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
            state_q        <= state_d;
            match_cnt_q    <= match_cnt_d;
        end
    end

`ifdef CLOCK_MONITOR_MINMAX_EN
    logic [CNT_W-1:0] min_half_q, min_half_d;
    logic [CNT_W-1:0] max_half_q, max_half_d;

    // Clearing first lets a coincident measurement load both registers.
    always_comb begin
        min_half_d = stats_clr ? CNT_MAX : min_half_q;
        max_half_d = stats_clr ? '0 : max_half_q;
        if (meas_evt) begin
            if (measured < min_half_d) min_half_d = measured;
            if (measured > max_half_d) max_half_d = measured;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min_half_q <= CNT_MAX;
            max_half_q <= '0;
        end else begin
            min_half_q <= min_half_d;
            max_half_q <= max_half_d;
        end
    end

    assign min_half = min_half_q;
    assign max_half = max_half_q;
`endif

    assign edge_rise     = edge_rise_q;
    assign edge_fall     = edge_fall_q;
    assign half_period   = half_period_q;
    assign period_valid  = period_valid_q;
    assign locked        = locked_q;
    assign timeout       = timeout_q;
    assign dbg_state     = state_q;
    assign dbg_match_cnt = match_cnt_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: lock acquisition, loss, timeout, edge-vs-timeout and reset.
module tb_clock_monitor;

  localparam int CNT_W = 16;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_LOST    = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic             sig_in;
  logic             edge_rise, edge_fall, period_valid, locked, timeout;
  logic [CNT_W-1:0] half_period;
  logic [1:0]       dbg_state;
  logic [2:0]       dbg_match_cnt;
`ifdef CLOCK_MONITOR_MINMAX_EN
  logic             stats_clr;
  logic [CNT_W-1:0] min_half, max_half;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clock_monitor #(
    .CNT_W(CNT_W), .EXPECT_HALF(10), .TOL(1), .LOCK_COUNT(4), .TIMEOUT_CYC(25)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef CLOCK_MONITOR_MINMAX_EN
    .stats_clr(stats_clr),
    .min_half(min_half),
    .max_half(max_half),
`endif
    .sig_in(sig_in),
    .edge_rise(edge_rise),
    .edge_fall(edge_fall),
    .half_period(half_period),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout),
    .dbg_state(dbg_state),
    .dbg_match_cnt(dbg_match_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Toggle sig_in and hold it for len cycles; the edge it creates reports the previous half.
  task automatic do_half(input int len, input bit pv, input int hp, input logic [1:0] st,
                         input int mc, input bit lk);
    sig_in = !sig_in;
    tick;
    tick;
    check("edge_early", {edge_rise, edge_fall}, 2'b00);
    tick;
    check("edge_rise", edge_rise, sig_in);
    check("edge_fall", edge_fall, !sig_in);
    check("period_valid", period_valid, pv);
    check("half_period", half_period, hp);
    check("state", dbg_state, st);
    check("timeout_at_edge", timeout, 1'b0);
    if (mc >= 0) check("match_cnt", dbg_match_cnt, mc);
    tick;
    check("pulse_width", {edge_rise, edge_fall, period_valid}, 3'b000);
    check("locked", locked, lk);
    repeat (len - 4) tick;
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
`ifdef CLOCK_MONITOR_MINMAX_EN
    stats_clr = 1'b0;
`endif
    repeat (3) tick;
    check("rst_outputs", {edge_rise, edge_fall, period_valid, locked, timeout}, 5'b0);
    check("rst_half_period", half_period, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;

    // Idle with no edges: no timeout outside ACQUIRE/LOCKED/LOST.
    repeat (30) tick;
    check("idle_state", dbg_state, ST_IDLE);
    check("idle_no_timeout", timeout, 1'b0);

    // Lock acquisition with a steady half-period of 10.
    do_half(10, 0, 0,  ST_ACQUIRE, 0, 0);
    do_half(10, 1, 10, ST_ACQUIRE, 1, 0);
    do_half(10, 1, 10, ST_ACQUIRE, 2, 0);
    do_half(10, 1, 10, ST_ACQUIRE, 3, 0);
    do_half(10, 1, 10, ST_LOCKED,  4, 1);
    // One long half (13) breaks lock, the following 10 re-enters ACQUIRE.
    do_half(13, 1, 10, ST_LOCKED,  -1, 1);
    do_half(10, 1, 13, ST_LOST,    -1, 0);
    // Alternating 11,9,12 then 11,9,10,11.
    do_half(11, 1, 10, ST_ACQUIRE, 1, 0);
    do_half(9,  1, 11, ST_ACQUIRE, 2, 0);
    do_half(12, 1, 9,  ST_ACQUIRE, 3, 0);
    do_half(11, 1, 12, ST_ACQUIRE, 0, 0);
    do_half(9,  1, 11, ST_ACQUIRE, 1, 0);
    do_half(10, 1, 9,  ST_ACQUIRE, 2, 0);
    do_half(11, 1, 10, ST_ACQUIRE, 3, 0);

    // Locked, then hold sig_in: timeout appears 25 cycles after the edge.
    do_half(4, 1, 11, ST_LOCKED, 4, 1);
    repeat (23) tick;
    check("timeout_before", timeout, 1'b0);
    check("locked_before_to", locked, 1'b1);
    tick;
    check("timeout_set", timeout, 1'b1);
    check("to_state_lost", dbg_state, ST_LOST);
    tick;
    check("locked_after_to", locked, 1'b0);
    repeat (11) tick;
    check("timeout_held", timeout, 1'b1);
    // Edge after 40 idle cycles reports the true count and clears timeout.
    do_half(25, 1, 40, ST_LOST, -1, 0);
    // Edge arriving exactly at the 25-cycle threshold wins over timeout.
    do_half(10, 1, 25, ST_LOST,    -1, 0);
    do_half(10, 1, 10, ST_ACQUIRE, 1, 0);
    do_half(10, 1, 10, ST_ACQUIRE, 2, 0);
    do_half(10, 1, 10, ST_ACQUIRE, 3, 0);
    do_half(10, 1, 10, ST_LOCKED,  4, 1);
    check("sig_high_locked", {sig_in, locked}, 2'b11);

    // Reset mid-lock with sig_in high.
    reset = 1'b1;
    tick;
    check("midrst_outputs", {edge_rise, edge_fall, period_valid, locked, timeout}, 5'b0);
    check("midrst_half_period", half_period, 0);
    check("midrst_state", dbg_state, ST_IDLE);
`ifdef CLOCK_MONITOR_MINMAX_EN
    check("midrst_min", min_half, 16'hFFFF);
    check("midrst_max", max_half, 0);
`endif
    tick;
    reset = 1'b0;
    tick;
    tick;
    check("rel_no_edge", {edge_rise, edge_fall}, 2'b00);
    tick;
    check("rel_edge_rise", {edge_rise, edge_fall}, 2'b10);
    check("rel_no_pv", period_valid, 1'b0);
    check("rel_half_period", half_period, 0);
    check("rel_state", dbg_state, ST_ACQUIRE);
    repeat (7) tick;

    // Half-periods 10, 8, 12, then 9 with a coincident stats clear.
    do_half(8,  1, 10, ST_ACQUIRE, 1, 0);
    do_half(12, 1, 8,  ST_ACQUIRE, 0, 0);
    do_half(9,  1, 12, ST_ACQUIRE, 0, 0);
`ifdef CLOCK_MONITOR_MINMAX_EN
    check("min_half", min_half, 8);
    check("max_half", max_half, 12);
`endif
    sig_in = !sig_in;
    tick;
    tick;
`ifdef CLOCK_MONITOR_MINMAX_EN
    stats_clr = 1'b1;
`endif
    tick;
`ifdef CLOCK_MONITOR_MINMAX_EN
    stats_clr = 1'b0;
    check("clr_min", min_half, 9);
    check("clr_max", max_half, 9);
`endif
    check("last_pv", period_valid, 1'b1);
    check("last_half_period", half_period, 9);
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
